// File: rtl/dsp_bist_pkg.sv
// Shared types and constants for the DSP48A1 register-stage self-test engine.
package dsp_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET_DUT,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [7:0]  NO_FAIL   = 8'hFF;

  // Right-shifting Galois step for x^32+x^22+x^2+x+1
  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    return {1'b0, q[31:1]} ^ (q[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/reg_stage_bist_if.sv
// Bundle between the self-test engine (master) and the register stage under check (slave).
interface reg_stage_bist_if #(
  parameter int SIZE = 18
);
  logic            start;
  logic [SIZE-1:0] dut_out;
  logic [SIZE-1:0] drive_in;
  logic            drive_ce;
  logic            drive_rst;
  logic            busy;
  logic            done;
  logic            pass;
  logic [7:0]      err_count;
  logic [7:0]      first_fail_idx;

  modport master (
    input  start, dut_out,
    output drive_in, drive_ce, drive_rst, busy, done, pass, err_count, first_fail_idx
  );

  modport slave (
    output start, dut_out,
    input  drive_in, drive_ce, drive_rst, busy, done, pass, err_count, first_fail_idx
  );
endinterface

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with seed load and step enable; reset also loads the seed.
module lfsr32
  import dsp_bist_pkg::*;
(
  input  logic        clk,
  input  logic        RST,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (RST || load) begin
      q <= seed;
    end else if (advance) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/reg_stage_bist.sv
// Stimulus-and-check engine for a DSP48A1 register-mux stage: drives LFSR vectors,
// tracks a shadow copy of the stage and counts output mismatches.
module reg_stage_bist
  import dsp_bist_pkg::*;
#(
  parameter int          SIZE        = 18,
  parameter int          SEL         = 1,
  parameter int          NUM_VECTORS = 10,
  parameter int          RST_CYCLES  = 2,
  parameter int          RST_EVERY   = 0,
  parameter int          CE_RANDOM   = 0,
  parameter logic [31:0] SEED        = 32'hACE1_1234
) (
  input logic           clk,
  input logic           RST,
  reg_stage_bist_if.master bus
);

  localparam int         RE_DIV   = (RST_EVERY == 0) ? 1 : RST_EVERY;
  localparam logic [7:0]  LAST_VEC = 8'(NUM_VECTORS - 1);
  localparam logic [15:0] LAST_RST = 16'(RST_CYCLES - 1);

  state_t          state;
  logic [15:0]     rcnt;
  logic [7:0]      vidx;
  logic [SIZE-1:0] shadow;
  logic [SIZE-1:0] expected;
  logic [31:0]     lfsr_q;
  logic            load;
  logic            advance;
  logic            cmp_en;
  logic            mismatch;
  logic [7:0]      err_next;
  logic            lfsr_unused;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic vec_rst(input logic [7:0] k);
    return (RST_EVERY != 0) && (((int'(k) + 1) % RE_DIV) == 0);
  endfunction

  function automatic logic vec_ce(input logic [31:0] l);
    return (CE_RANDOM != 0) ? l[31] : 1'b1;
  endfunction

  lfsr32 u_lfsr (
    .clk    (clk),
    .RST    (RST),
    .load   (load),
    .seed   (SEED),
    .advance(advance),
    .q      (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q;

  always_comb begin
    load     = (state == IDLE) && bus.start;
    advance  = ((state == RESET_DUT) && (rcnt == LAST_RST)) ||
               ((state == RUN) && (vidx != LAST_VEC));
    expected = (SEL != 0) ? shadow : bus.drive_in;
    if (SEL != 0) begin
      cmp_en = ((state == RUN) && (vidx != 8'd0)) || (state == DRAIN);
    end else begin
      cmp_en = (state == RUN);
    end
    mismatch = cmp_en && (bus.dut_out != expected);
    err_next = mismatch ? sat_inc(bus.err_count) : bus.err_count;
  end

  // Shadow follows the same reset/enable rule as the stage under check
  always_ff @(posedge clk) begin
    if (RST || bus.drive_rst) begin
      shadow <= '0;
    end else if (bus.drive_ce) begin
      shadow <= bus.drive_in;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state              <= IDLE;
      rcnt               <= '0;
      vidx               <= '0;
      bus.drive_in       <= '0;
      bus.drive_ce       <= 1'b0;
      bus.drive_rst      <= 1'b0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.pass           <= 1'b0;
      bus.err_count      <= '0;
      bus.first_fail_idx <= NO_FAIL;
    end else begin
      bus.done <= 1'b0;
      if (mismatch) begin
        bus.err_count <= err_next;
        if (bus.first_fail_idx == NO_FAIL) bus.first_fail_idx <= vidx;
      end
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state              <= RESET_DUT;
            rcnt               <= '0;
            vidx               <= '0;
            bus.busy           <= 1'b1;
            bus.pass           <= 1'b0;
            bus.err_count      <= '0;
            bus.first_fail_idx <= NO_FAIL;
            bus.drive_in       <= '0;
            bus.drive_ce       <= 1'b1;
            bus.drive_rst      <= 1'b1;
          end
        end
        RESET_DUT: begin
          if (rcnt == LAST_RST) begin
            state         <= RUN;
            bus.drive_in  <= lfsr_q[SIZE-1:0];
            bus.drive_ce  <= vec_ce(lfsr_q);
            bus.drive_rst <= vec_rst(8'd0);
          end else begin
            rcnt <= rcnt + 16'd1;
          end
        end
        RUN: begin
          if (vidx == LAST_VEC) begin
            state         <= DRAIN;
            bus.drive_ce  <= 1'b0;
            bus.drive_rst <= 1'b0;
          end else begin
            vidx          <= vidx + 8'd1;
            bus.drive_in  <= lfsr_q[SIZE-1:0];
            bus.drive_ce  <= vec_ce(lfsr_q);
            bus.drive_rst <= vec_rst(vidx + 8'd1);
          end
        end
        DRAIN: begin
          // err_next folds in a mismatch seen this cycle before the verdict
          state    <= DONE;
          bus.done <= 1'b1;
          bus.pass <= (err_next == 8'd0);
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_stage_bist.sv
// Directed bench for reg_stage_bist: four engine configurations, each paired with a
// behavioural register stage (golden or faulty); results checked against a queue-based model.
module tb_reg_stage_bist;

  localparam logic [31:0] SEED = 32'hACE1_1234;
  localparam int          RSTC = 2;

  typedef struct {
    int   len;
    int   err;
    int   ffi;
    logic pass;
  } res_t;

  typedef struct {
    logic [17:0] din;
    logic        ce;
    logic        rst;
  } drv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force0 = 1'b0;
  logic ce_brk = 1'b0;
  logic start_v [4];

  logic        busy_a [4];
  logic        done_a [4];
  logic        pass_a [4];
  logic [7:0]  err_a  [4];
  logic [7:0]  ffi_a  [4];
  logic [17:0] din_a  [4];
  logic        ce_a   [4];
  logic        drst_a [4];

  res_t res_q[$];
  drv_t drv_q[$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gu
    localparam int SELG = (g == 1 || g == 3) ? 0 : 1;
    localparam int NVG  = (g == 3) ? 255 : 10;
    localparam int REVG = (g == 1) ? 3 : 0;
    localparam int CERG = (g == 2) ? 1 : 0;

    reg_stage_bist_if #(.SIZE(18)) bus ();
    logic [17:0] sreg;

    reg_stage_bist #(
      .SIZE(18), .SEL(SELG), .NUM_VECTORS(NVG), .RST_CYCLES(RSTC),
      .RST_EVERY(REVG), .CE_RANDOM(CERG), .SEED(SEED)
    ) dut (
      .clk(clk),
      .RST(rst),
      .bus(bus)
    );

    // Stage under check: 0 = register with bit0 fault option, 1 = bypass wire,
    // 2 = register with CE fault option, 3 = stuck-at-0
    always_ff @(posedge clk) begin
      if (bus.drive_rst) sreg <= '0;
      else if (bus.drive_ce || (g == 2 && ce_brk)) sreg <= bus.drive_in;
    end

    assign bus.dut_out = (g == 1) ? bus.drive_in :
                         (g == 3) ? 18'd0 :
                         (sreg | {17'd0, (g == 0) && force0});
    assign bus.start = start_v[g];
    assign busy_a[g] = bus.busy;
    assign done_a[g] = bus.done;
    assign pass_a[g] = bus.pass;
    assign err_a[g]  = bus.err_count;
    assign ffi_a[g]  = bus.first_fail_idx;
    assign din_a[g]  = bus.drive_in;
    assign ce_a[g]   = bus.drive_ce;
    assign drst_a[g] = bus.drive_rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // Reference model of one complete test: vectors, stage behaviour, verdict
  task automatic model(input int sel, input int nv, input int rev, input int cer,
                       input int fault, input bit push_drv);
    logic [31:0] l;
    logic [17:0] g, f, din, obs, exp_v;
    logic        ce, r;
    int          err, ffi;
    drv_t        d;
    res_t        rr;
    l = SEED; g = '0; f = '0; err = 0; ffi = 255;
    for (int k = 0; k < nv; k++) begin
      din = l[17:0];
      ce  = (cer != 0) ? l[31] : 1'b1;
      r   = (rev != 0) && (((k + 1) % rev) == 0);
      if (push_drv) begin
        d.din = din; d.ce = ce; d.rst = r;
        drv_q.push_back(d);
      end
      if (sel != 0) begin
        exp_v = g;
        obs   = (fault == 1) ? (f | 18'd1) : f;
      end else begin
        exp_v = din;
        obs   = (fault == 3) ? 18'd0 : din;
      end
      if ((sel == 0 || k > 0) && obs != exp_v) begin
        if (err < 255) err++;
        if (ffi == 255) ffi = k;
      end
      g = r ? 18'd0 : (ce ? din : g);
      f = r ? 18'd0 : ((ce || fault == 2) ? din : f);
      l = {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
    end
    if (sel != 0) begin
      obs = (fault == 1) ? (f | 18'd1) : f;
      if (obs != g) begin
        if (err < 255) err++;
        if (ffi == 255) ffi = nv - 1;
      end
    end
    rr.len = RSTC + nv + 2; rr.err = err; rr.ffi = ffi; rr.pass = (err == 0);
    res_q.push_back(rr);
  endtask

  task automatic run_test(input int u, input int nv, input bit chk_drv, input string tag);
    res_t rr;
    drv_t d;
    int   c, blen, dn;
    logic p;
    logic [7:0] e, ff;
    p = 1'bx; e = 'x; ff = 'x;
    start_v[u] = 1'b1;
    tick();
    start_v[u] = 1'b0;
    c = 0; blen = 0; dn = 0;
    while (c < 600) begin
      c++;
      if (busy_a[u]) blen++;
      if (chk_drv && c >= RSTC + 1 && c < RSTC + 1 + nv && drv_q.size() > 0) begin
        d = drv_q.pop_front();
        chk($sformatf("%s_din%0d", tag, c - RSTC - 1), 32'(din_a[u]), 32'(d.din));
        chk($sformatf("%s_ce%0d", tag, c - RSTC - 1), 32'(ce_a[u]), 32'(d.ce));
        chk($sformatf("%s_rst%0d", tag, c - RSTC - 1), 32'(drst_a[u]), 32'(d.rst));
      end
      if (done_a[u]) begin
        dn++; p = pass_a[u]; e = err_a[u]; ff = ffi_a[u];
      end
      if (!busy_a[u]) break;
      tick();
    end
    if (chk_drv) chk({tag, "_drv_left"}, 32'(drv_q.size()), 32'd0);
    rr = res_q.pop_front();
    chk({tag, "_busy_len"}, 32'(blen), 32'(rr.len));
    chk({tag, "_done_cnt"}, 32'(dn), 32'd1);
    chk({tag, "_pass"}, 32'(p), 32'(rr.pass));
    chk({tag, "_err"}, 32'(e), 32'(rr.err));
    chk({tag, "_ffi"}, 32'(ff), 32'(rr.ffi));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy_a[0]), 32'd0);
    chk({tag, "_done"}, 32'(done_a[0]), 32'd0);
    chk({tag, "_pass"}, 32'(pass_a[0]), 32'd0);
    chk({tag, "_err"}, 32'(err_a[0]), 32'd0);
    chk({tag, "_ffi"}, 32'(ffi_a[0]), 32'hFF);
    chk({tag, "_din"}, 32'(din_a[0]), 32'd0);
    chk({tag, "_ce"}, 32'(ce_a[0]), 32'd0);
    chk({tag, "_drst"}, 32'(drst_a[0]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset("reset");

    model(1, 10, 0, 0, 0, 1'b0);
    run_test(0, 10, 1'b0, "golden");

    force0 = 1'b1;
    model(1, 10, 0, 0, 1, 1'b0);
    run_test(0, 10, 1'b0, "bit0");
    force0 = 1'b0;

    model(0, 10, 3, 0, 0, 1'b1);
    run_test(1, 10, 1'b1, "bypass_rev3");

    model(1, 10, 0, 1, 0, 1'b1);
    run_test(2, 10, 1'b1, "ce_rand");

    ce_brk = 1'b1;
    model(1, 10, 0, 1, 2, 1'b0);
    run_test(2, 10, 1'b0, "ce_brk");
    chk("ce_brk_nonzero", 32'(err_a[2] != 8'd0), 32'd1);
    ce_brk = 1'b0;

    // Abort mid-test while vector 4 is being driven
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int i = 0; i < RSTC + 4; i++) tick();
    chk("abort_at_vec4", 32'(busy_a[0]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("abort");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("abort_nodone%0d", i), 32'(done_a[0] | busy_a[0]), 32'd0);
    end

    model(1, 10, 0, 0, 0, 1'b0);
    run_test(0, 10, 1'b0, "after_abort");

    model(0, 255, 0, 0, 3, 1'b0);
    run_test(3, 255, 1'b0, "stuck0");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
